// File: rtl/calc_req_arbiter.sv
// -----------------------------------------------------------------------------
// calc_req_arbiter
//
// Shares a single calculator between two requesters. A round-robin choice is
// made in IDLE. The winner's op/operands are latched onto the calculator
// inputs and go is pulsed for one cycle. The arbiter then waits for done, or
// for a timeout if the calculator hangs. The result is returned to the winner
// with a one-cycle ack. Finally it drains any level-held done before it
// accepts the next request. The op code is passed through untouched.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 synchronous active-high reset
//   req0/op0/a0/b0      requester 0 request, op code, operands (held until ack0)
//   ack0/res0/err0      requester 0 completion pulse, result, timeout flag
//   req1/op1/a1/b1      requester 1 request, op code, operands (held until ack1)
//   ack1/res1/err1      requester 1 completion pulse, result, timeout flag
//   calc_go             one-cycle start pulse to the calculator
//   calc_op/in1/in2     op code and operands presented to the calculator
//   calc_done/calc_out  calculator completion level and result
//   busy                high whenever the FSM is not in IDLE
//   grant_id            requester currently being served (valid while busy)
//
// Parameters
//   TIMEOUT  maximum number of WAIT cycles before aborting with err (>= 2)
//   CNT_W    width of the timeout counter (2**CNT_W > TIMEOUT)
// -----------------------------------------------------------------------------
module calc_req_arbiter #(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst,
    // requester 0
    input  logic       req0,
    input  logic [1:0] op0,
    input  logic [2:0] a0,
    input  logic [2:0] b0,
    output logic       ack0,
    output logic [2:0] res0,
    output logic       err0,
    // requester 1
    input  logic       req1,
    input  logic [1:0] op1,
    input  logic [2:0] a1,
    input  logic [2:0] b1,
    output logic       ack1,
    output logic [2:0] res1,
    output logic       err1,
    // calculator side
    output logic       calc_go,
    output logic [1:0] calc_op,
    output logic [2:0] calc_in1,
    output logic [2:0] calc_in2,
    input  logic       calc_done,
    input  logic [2:0] calc_out,
    // status
    output logic       busy,
    output logic       grant_id
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    // Last WAIT cycle index; reaching it with done still low aborts the op.
    localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state_r;
    logic [2:0]       state_nx_s;
    logic             ptr_r;          // requester preferred on a tie
    logic             grant_id_r;
    logic             grant_s;        // a grant is taken this cycle
    logic             grant_nx_s;     // requester being granted this cycle
    logic             done_hit_s;     // WAIT ends with a valid result
    logic             timeout_hit_s;  // WAIT ends by timeout
    logic [CNT_W-1:0] timer_r;

    logic             calc_go_r;
    logic [1:0]       calc_op_r;
    logic [2:0]       calc_in1_r;
    logic [2:0]       calc_in2_r;
    logic             ack0_r;
    logic             ack1_r;
    logic [2:0]       res0_r;
    logic [2:0]       res1_r;
    logic             err0_r;
    logic             err1_r;
    logic             busy_r;

    // Next-state decode, arbitration and WAIT exit qualification.
    always_comb begin
        state_nx_s    = state_r;
        grant_s       = 1'b0;
        grant_nx_s    = grant_id_r;
        done_hit_s    = 1'b0;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req0 && req1) begin
                    // Tie: serve whoever was not served last.
                    grant_s    = 1'b1;
                    grant_nx_s = ptr_r;
                    state_nx_s = ST_ISSUE;
                end else if (req0) begin
                    grant_s    = 1'b1;
                    grant_nx_s = 1'b0;
                    state_nx_s = ST_ISSUE;
                end else if (req1) begin
                    grant_s    = 1'b1;
                    grant_nx_s = 1'b1;
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nx_s = ST_WAIT;
            end
            ST_WAIT: begin
                // Done has priority over a coincident timeout.
                if (calc_done) begin
                    done_hit_s = 1'b1;
                    state_nx_s = ST_RESP;
                end else if (timer_r == TMR_LAST) begin
                    timeout_hit_s = 1'b1;
                    state_nx_s    = ST_RESP;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_nx_s = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Hold off until a level-held done falls so it cannot
                // complete the next operation early.
                if (calc_done) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Grant bookkeeping: winner id, round-robin pointer and operand latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id_r <= 1'b0;
            ptr_r      <= 1'b0;
            calc_op_r  <= 2'd0;
            calc_in1_r <= 3'd0;
            calc_in2_r <= 3'd0;
        end else if (grant_s) begin
            grant_id_r <= grant_nx_s;
            ptr_r      <= ~grant_nx_s;
            calc_op_r  <= grant_nx_s ? op1 : op0;
            calc_in1_r <= grant_nx_s ? a1  : a0;
            calc_in2_r <= grant_nx_s ? b1  : b0;
        end else begin
            grant_id_r <= grant_id_r;
            ptr_r      <= ptr_r;
            calc_op_r  <= calc_op_r;
            calc_in1_r <= calc_in1_r;
            calc_in2_r <= calc_in2_r;
        end
    end

    // Go pulse: high for exactly the ISSUE cycle that follows a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            calc_go_r <= 1'b0;
        end else begin
            calc_go_r <= grant_s;
        end
    end

    // WAIT cycle counter, cleared in ISSUE and frozen once WAIT is left.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_ISSUE) begin
            timer_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_WAIT) && !done_hit_s && !timeout_hit_s) begin
            timer_r <= timer_r + CNT_W'(1'b1);
        end else begin
            timer_r <= timer_r;
        end
    end

    // Ack pulses: raised on the WAIT->RESP edge so they are high in RESP only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
        end else begin
            ack0_r <= (done_hit_s | timeout_hit_s) & ~grant_id_r;
            ack1_r <= (done_hit_s | timeout_hit_s) &  grant_id_r;
        end
    end

    // Requester 0 result/error: result only on done, error cleared on done
    // and set on timeout; both hold between operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            res0_r <= 3'd0;
            err0_r <= 1'b0;
        end else if (!grant_id_r && done_hit_s) begin
            res0_r <= calc_out;
            err0_r <= 1'b0;
        end else if (!grant_id_r && timeout_hit_s) begin
            res0_r <= res0_r;
            err0_r <= 1'b1;
        end else begin
            res0_r <= res0_r;
            err0_r <= err0_r;
        end
    end

    // Requester 1 result/error, same rules as requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            res1_r <= 3'd0;
            err1_r <= 1'b0;
        end else if (grant_id_r && done_hit_s) begin
            res1_r <= calc_out;
            err1_r <= 1'b0;
        end else if (grant_id_r && timeout_hit_s) begin
            res1_r <= res1_r;
            err1_r <= 1'b1;
        end else begin
            res1_r <= res1_r;
            err1_r <= err1_r;
        end
    end

    // Busy flag tracks the registered state (high outside IDLE).
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s != ST_IDLE);
        end
    end

    assign calc_go  = calc_go_r;
    assign calc_op  = calc_op_r;
    assign calc_in1 = calc_in1_r;
    assign calc_in2 = calc_in2_r;
    assign ack0     = ack0_r;
    assign ack1     = ack1_r;
    assign res0     = res0_r;
    assign res1     = res1_r;
    assign err0     = err0_r;
    assign err1     = err1_r;
    assign busy     = busy_r;
    assign grant_id = grant_id_r;

endmodule

// File: tb/tb_calc_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_calc_req_arbiter
//
// Directed bench for calc_req_arbiter (TIMEOUT=8). A cycle-by-cycle vector
// table covers reset, a single operation, a reset in the middle of WAIT and
// the tie-break after reset. Hand-written sequences drive a small calculator
// model and cover contention, timeout, done on the timeout boundary and a
// level-held done.
// -----------------------------------------------------------------------------
module tb_calc_req_arbiter;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [2:0] a0, b0, a1, b1;
    logic       ack0, ack1, err0, err1;
    logic [2:0] res0, res1;
    logic       calc_go, calc_done;
    logic [1:0] calc_op;
    logic [2:0] calc_in1, calc_in2, calc_out;
    logic       busy, grant_id;

    calc_req_arbiter #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .ack0(ack0), .res0(res0), .err0(err0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .ack1(ack1), .res1(res1), .err1(err1),
        .calc_go(calc_go), .calc_op(calc_op),
        .calc_in1(calc_in1), .calc_in2(calc_in2),
        .calc_done(calc_done), .calc_out(calc_out),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst; logic r0; logic [1:0] o0; logic [2:0] ia0; logic [2:0] ib0;
        logic r1; logic [1:0] o1; logic [2:0] ia1; logic [2:0] ib1;
        logic dn; logic [2:0] dout;
        logic [20:0] exp;   // {go,busy,gid,op,in1,in2,ack0,res0,err0,ack1,res1,err1}
    } vec_t;

    vec_t tbl[$];

    int checks = 0;
    int errors = 0;

    // calculator model state
    int         m_cnt, m_delay, m_hold, go_cnt;
    bit         m_act, m_never;
    logic [2:0] m_out;

    // sequence bookkeeping
    bit   ok, got1;
    int   n, n2, n0, n1, k0, k1, gi, both;
    logic gseq [8];

    function automatic vec_t mk(input int rs, input int r0, input int o0, input int x0, input int y0,
                                input int r1, input int o1, input int x1, input int y1,
                                input int dn, input int dout,
                                input int go, input int bs, input int gid, input int op,
                                input int i1, input int i2,
                                input int k0_, input int s0, input int e0,
                                input int k1_, input int s1, input int e1);
        vec_t v;
        v.rst = 1'(rs); v.r0 = 1'(r0); v.o0 = 2'(o0); v.ia0 = 3'(x0); v.ib0 = 3'(y0);
        v.r1 = 1'(r1); v.o1 = 2'(o1); v.ia1 = 3'(x1); v.ib1 = 3'(y1);
        v.dn = 1'(dn); v.dout = 3'(dout);
        v.exp = {1'(go), 1'(bs), 1'(gid), 2'(op), 3'(i1), 3'(i2),
                 1'(k0_), 3'(s0), 1'(e0), 1'(k1_), 3'(s1), 1'(e1)};
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle of the calculator model, evaluated at the falling edge.
    // Done is high for cycles go+m_delay .. go+m_delay+m_hold, out = in1+in2.
    task tick();
        @(negedge clk);
        if (calc_go) begin
            m_act = 1'b1;
            m_cnt = 0;
            m_out = calc_in1 + calc_in2;
            go_cnt++;
        end else if (m_act) begin
            m_cnt++;
        end
        if (m_act && !m_never && m_cnt >= m_delay && m_cnt <= m_delay + m_hold) begin
            calc_done = 1'b1;
            calc_out  = m_out;
        end else begin
            calc_done = 1'b0;
            if (m_act && !m_never && m_cnt > m_delay + m_hold) m_act = 1'b0;
        end
    endtask

    task wait_go(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (calc_go) begin
                seen = 1'b1;
                break;
            end
        end
        chk("go_seen", int'(seen), 1);
    endtask

    task wait_idle();
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        chk("back_to_idle", int'(idle), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        op0 = 2'd0; op1 = 2'd0; a0 = 3'd0; b0 = 3'd0; a1 = 3'd0; b1 = 3'd0;
        calc_done = 1'b0; calc_out = 3'd0;
        m_cnt = 0; m_delay = 2; m_hold = 0; m_act = 1'b0; m_never = 1'b0;
        m_out = 3'd0; go_cnt = 0;

        //           rst r0 o0 a0 b0  r1 o1 a1 b1  dn out  go bs id op i1 i2  k0 s0 e0  k1 s1 e1
        // reset and single op: done 4 cycles after go with out=5
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0,0,0, 0,0,0));
        tbl.push_back(mk(0, 1,0,3,2, 0,0,0,0, 0,0, 1,1,0,0,3,2, 0,0,0, 0,0,0));
        tbl.push_back(mk(0, 1,0,3,2, 0,0,0,0, 0,0, 0,1,0,0,3,2, 0,0,0, 0,0,0));
        tbl.push_back(mk(0, 1,0,3,2, 0,0,0,0, 0,0, 0,1,0,0,3,2, 0,0,0, 0,0,0));
        tbl.push_back(mk(0, 1,0,3,2, 0,0,0,0, 0,0, 0,1,0,0,3,2, 0,0,0, 0,0,0));
        tbl.push_back(mk(0, 1,0,3,2, 0,0,0,0, 0,0, 0,1,0,0,3,2, 0,0,0, 0,0,0));
        tbl.push_back(mk(0, 1,0,3,2, 0,0,0,0, 1,5, 0,1,0,0,3,2, 1,5,0, 0,0,0));
        tbl.push_back(mk(0, 0,0,3,2, 0,0,0,0, 0,0, 0,1,0,0,3,2, 0,5,0, 0,0,0));
        tbl.push_back(mk(0, 0,0,3,2, 0,0,0,0, 0,0, 0,0,0,0,3,2, 0,5,0, 0,0,0));
        tbl.push_back(mk(0, 0,0,3,2, 0,0,0,0, 0,0, 0,0,0,0,3,2, 0,5,0, 0,0,0));
        // reset two cycles after go: no ack, everything back to reset values
        tbl.push_back(mk(0, 1,1,6,1, 0,0,0,0, 0,0, 1,1,0,1,6,1, 0,5,0, 0,0,0));
        tbl.push_back(mk(0, 1,1,6,1, 0,0,0,0, 0,0, 0,1,0,1,6,1, 0,5,0, 0,0,0));
        tbl.push_back(mk(0, 1,1,6,1, 0,0,0,0, 0,0, 0,1,0,1,6,1, 0,5,0, 0,0,0));
        tbl.push_back(mk(1, 1,1,6,1, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0,0,0, 0,0,0));
        // tie right after reset goes to req0, then req1 served alone
        tbl.push_back(mk(0, 1,2,7,7, 1,3,1,1, 0,0, 1,1,0,2,7,7, 0,0,0, 0,0,0));
        tbl.push_back(mk(0, 1,2,7,7, 1,3,1,1, 0,0, 0,1,0,2,7,7, 0,0,0, 0,0,0));
        tbl.push_back(mk(0, 1,2,7,7, 1,3,1,1, 1,3, 0,1,0,2,7,7, 1,3,0, 0,0,0));
        tbl.push_back(mk(0, 0,2,7,7, 1,3,1,1, 0,0, 0,1,0,2,7,7, 0,3,0, 0,0,0));
        tbl.push_back(mk(0, 0,2,7,7, 1,3,1,1, 0,0, 0,0,0,2,7,7, 0,3,0, 0,0,0));
        tbl.push_back(mk(0, 0,2,7,7, 1,3,1,1, 0,0, 1,1,1,3,1,1, 0,3,0, 0,0,0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0,0,0, 0,0,0));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst;
            req0 = tbl[i].r0; op0 = tbl[i].o0; a0 = tbl[i].ia0; b0 = tbl[i].ib0;
            req1 = tbl[i].r1; op1 = tbl[i].o1; a1 = tbl[i].ia1; b1 = tbl[i].ib1;
            calc_done = tbl[i].dn; calc_out = tbl[i].dout;
            @(posedge clk);
            #1;
            checks++;
            if ({calc_go, busy, grant_id, calc_op, calc_in1, calc_in2,
                 ack0, res0, err0, ack1, res1, err1} !== tbl[i].exp) begin
                errors++;
                $display("FAIL vec[%0d] go/busy/gid/op/in1/in2/ack0/res0/err0/ack1/res1/err1: got %0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d expected %b",
                         i, calc_go, busy, grant_id, calc_op, calc_in1, calc_in2,
                         ack0, res0, err0, ack1, res1, err1, tbl[i].exp);
            end
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; calc_done = 1'b0;

        // Contention: both held for three ops each, grants must alternate.
        m_delay = 2; m_hold = 0; m_never = 1'b0; go_cnt = 0;
        a0 = 3'd1; b0 = 3'd1; op0 = 2'd0; a1 = 3'd2; b1 = 3'd3; op1 = 2'd0;
        req0 = 1'b1; req1 = 1'b1;
        n0 = 0; n1 = 0; gi = 0; both = 0;
        for (int c = 0; c < 200 && (n0 < 3 || n1 < 3); c++) begin
            tick();
            if (calc_go && gi < 8) begin
                gseq[gi] = grant_id;
                gi++;
            end
            if (ack0 && ack1) both++;
            if (ack0) begin
                n0++;
                chk("cont_res0", int'(res0), 2);
                chk("cont_err0", int'(err0), 0);
                if (n0 == 3) req0 = 1'b0;
            end
            if (ack1) begin
                n1++;
                chk("cont_res1", int'(res1), 5);
                chk("cont_err1", int'(err1), 0);
                if (n1 == 3) req1 = 1'b0;
            end
        end
        wait_idle();
        chk("cont_ack0_count", n0, 3);
        chk("cont_ack1_count", n1, 3);
        chk("cont_go_count", go_cnt, 6);
        chk("cont_both_acks", both, 0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("cont_grant%0d", k), int'(gseq[k]), k % 2);
        end

        // Timeout: calculator never answers; ack1 8 cycles after WAIT entry.
        m_never = 1'b1;
        a1 = 3'd3; b1 = 3'd3; req1 = 1'b1;
        wait_go(ok);
        n = 0; got1 = 1'b0; k0 = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            n++;
            if (ack0) k0++;
            if (ack1) begin
                got1 = 1'b1;
                break;
            end
        end
        chk("to_ack_seen", int'(got1), 1);
        chk("to_ack_cycle", n, TO + 1);
        chk("to_err1", int'(err1), 1);
        chk("to_res1_kept", int'(res1), 5);
        chk("to_no_ack0", k0, 0);
        req1 = 1'b0;
        wait_idle();
        m_never = 1'b0; m_act = 1'b0;

        // Next op on requester 1 completes normally and clears err1.
        m_delay = 3; a1 = 3'd3; b1 = 3'd4; req1 = 1'b1;
        wait_go(ok);
        got1 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (ack1) begin
                got1 = 1'b1;
                break;
            end
        end
        chk("after_to_ack", int'(got1), 1);
        chk("after_to_res1", int'(res1), 7);
        chk("after_to_err1", int'(err1), 0);
        req1 = 1'b0;
        wait_idle();

        // Done in the last WAIT cycle: done wins over the timeout.
        m_delay = TO; a0 = 3'd3; b0 = 3'd3; req0 = 1'b1;
        wait_go(ok);
        n = 0; ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            n++;
            if (ack0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bnd_ack_seen", int'(ok), 1);
        chk("bnd_ack_cycle", n, TO + 1);
        chk("bnd_err0", int'(err0), 0);
        chk("bnd_res0", int'(res0), 6);
        req0 = 1'b0;
        wait_idle();

        // Level-held done: one ack, DRAIN until done falls, then req1.
        m_delay = 2; m_hold = 5; a0 = 3'd1; b0 = 3'd2; op0 = 2'd1; req0 = 1'b1;
        wait_go(ok);
        a1 = 3'd2; b1 = 3'd2; op1 = 2'd2; req1 = 1'b1;
        n = 0; n2 = -1; k0 = 0; k1 = 0; got1 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            n++;
            if (ack0) begin
                k0++;
                req0 = 1'b0;
            end
            if (calc_go) begin
                n2 = n;
                m_hold = 0;
            end
            if (ack1) begin
                got1 = 1'b1;
                req1 = 1'b0;
                break;
            end
        end
        chk("lvl_ack0_count", k0, 1);
        chk("lvl_res0", int'(res0), 3);
        chk("lvl_second_go_cycle", n2, 10);
        chk("lvl_ack1_seen", int'(got1), 1);
        chk("lvl_res1", int'(res1), 4);
        chk("lvl_err1", int'(err1), 0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_req_arbiter.md
Name: calc_req_arbiter

Overview:
Shares one calculator_fpga instance between two requesters. Arbitrates round-robin, latches the winner's op/operands, and pulses the calculator's go. It then waits for done, returns the 3-bit result with a one-cycle ack, and guards against a hung calculator with a timeout. Sits between the requesters and the calculator top; op encoding is passed through opaque.

Parameters:
TIMEOUT, 32, max cycles in WAIT before aborting with error (must be >= 2)
CNT_W, 6, width of timeout counter (2^CNT_W > TIMEOUT)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req0  input  1  requester 0 request, held with stable operands until ack0
op0  input  2  requester 0 operation code
a0  input  3  requester 0 operand 1
b0  input  3  requester 0 operand 2
ack0  output  1  one-cycle completion pulse to requester 0
res0  output  3  result for requester 0, valid with ack0, held afterwards
err0  output  1  timeout flag, valid with ack0, held afterwards
req1, op1, a1, b1, ack1, res1, err1: same as above for requester 1
calc_go  output  1  go to calculator
calc_op  output  2  op to calculator
calc_in1  output  3  in1 to calculator
calc_in2  output  3  in2 to calculator
calc_done  input  1  calculator done (treated as a level)
calc_out  input  3  calculator result
busy  output  1  high in every state except IDLE
grant_id  output  1  index of requester being served (valid while busy)

Behaviour:
- Registered FSM with states IDLE, ISSUE, WAIT, RESP, DRAIN. All outputs are registered or decoded from registered state.
- Reset: state=IDLE; rr pointer prefers req0. calc_go, calc_op, calc_in1, calc_in2, ack0/1, res0/1, err0/1, busy, grant_id, timer are all 0.
- IDLE:
  - Only one request pending -> grant it.
  - Both pending -> grant the requester NOT served last (pointer); after reset req0 wins.
  - On grant: latch op/a/b into calc_op/calc_in1/calc_in2, set grant_id, flip pointer to the other requester, go to ISSUE.
  - No request -> stay.
- ISSUE: calc_go=1 for exactly this one cycle; timer cleared; next WAIT.
- WAIT:
  - calc_done=1 -> capture calc_out into res[grant_id], clear err[grant_id], go to RESP.
  - Otherwise timer increments. When timer==TIMEOUT-1 with done still low: set err[grant_id]=1, leave res[grant_id] unchanged, go to RESP.
  - Done and timeout in the same cycle: done wins, err=0.
- RESP: ack[grant_id]=1 for one cycle; the other ack stays 0; next DRAIN.
- DRAIN:
  - Stay while calc_done=1, then go to IDLE.
  - This prevents a level-held done from completing the next operation.
  - After a timeout, calc_done is normally 0, so DRAIN lasts one cycle.
- calc_op/calc_in1/calc_in2 stay stable from ISSUE through DRAIN. They change only at a new grant.
- Latency: grant at IDLE edge t. Go is high in cycle t+1. Done at cycle t+1+k gives ack at t+2+k. Minimum IDLE-to-IDLE is 5 cycles.
- Requester contract:
  - Drop req the cycle after ack unless another op is wanted.
  - A req still high when the FSM is back in IDLE counts as a new request. The arbiter has no queue.
- req changes while not in IDLE are ignored. Operand changes after grant have no effect.
- Reset asserted mid-operation (any state): next cycle returns to IDLE with all outputs at reset values; no ack issued. The calculator is reset from the same rst.

Test Plan:
- Single op: req0=1, op0=2'b00, a0=3, b0=2; calc model raises done 4 cycles after go with out=5 -> one go pulse; ack0 pulse with res0=5, err0=0; ack1 never asserts; busy returns low.
- Contention: req0 and req1 asserted in the same cycle, held across 3 ops each (a0=1,b0=1 vs a1=2,b1=3, add model) -> grants alternate 0,1,0,1,0,1; res0=2 on every ack0; res1=5 on every ack1; exactly one go per grant.
- Timeout: TIMEOUT=8, model never raises done -> ack1 exactly 8 cycles after the WAIT entry cycle, err1=1, res1 keeps its previous value. Next request then completes normally with err1 cleared.
- Level done: model holds done high 5 cycles after completing -> a single ack. FSM stays in DRAIN until done falls. A pending req1 is granted only after done=0, and its result comes from its own done.
- Done on timeout boundary: TIMEOUT=8, done arrives exactly in the 8th WAIT cycle -> err=0, res=calc_out.
- Reset mid-WAIT: rst pulsed 2 cycles after go -> busy=0, calc_go=0, no ack, pointer prefers req0. A fresh req0 is then served normally.
